// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer and its uni_shift consumers:
// FSM state encoding and the downstream control (clt) codes.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] CLT_HOLD = 2'b00;
  localparam logic [1:0] CLT_SHL  = 2'b01;
  localparam logic [1:0] CLT_SHR  = 2'b10;
  localparam logic [1:0] CLT_LOAD = 2'b11;

  function automatic logic [1:0] shift_clt(input logic dir);
    return dir ? CLT_SHR : CLT_SHL;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Remaining-shift counter: parallel load, decrement saturating at zero,
// and a zero flag.
module shift_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Counter register; load takes priority over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/shift_seq.sv
// Command-driven sequencer for a downstream uni_shift register: loads a word,
// issues len shift controls, mirrors the shifts in a shadow copy, reports the result.
module shift_seq
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_len,
  input  logic [N-1:0]  cmd_data,
  input  logic          ser_in,
  output logic [1:0]    clt,
  output logic [N-1:0]  d,
  output logic          ser_out,
  output logic          ser_out_valid,
  output logic          done,
  output logic [N-1:0]  res_data
);

  state_t        state_r, state_nx_s;
  logic          dir_r;
  logic [N-1:0]  data_r;
  logic [N-1:0]  shadow_r;
  logic          accept_s;
  logic [CW-1:0] len_clamp_s;
  logic [CW-1:0] cnt_s;
  logic          cnt_zero_s;
  logic          last_shift_s;

  assign accept_s     = (state_r == ST_IDLE) && cmd_valid;
  assign len_clamp_s  = (cmd_len > CW'(N)) ? CW'(N) : cmd_len;
  assign last_shift_s = (cnt_s == {{(CW-1){1'b0}}, 1'b1});

  shift_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .dec      (state_r == ST_SHIFT),
    .load_val (len_clamp_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command capture and shadow copy of the downstream register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r    <= 1'b0;
      data_r   <= {N{1'b0}};
      shadow_r <= {N{1'b0}};
    end else begin
      if (accept_s) begin
        dir_r  <= cmd_dir;
        data_r <= cmd_data;
      end else begin
        dir_r  <= dir_r;
        data_r <= data_r;
      end
      case (state_r)
        ST_LOAD:  shadow_r <= data_r;
        ST_SHIFT: shadow_r <= dir_r ? {ser_in, shadow_r[N-1:1]}
                                    : {shadow_r[N-2:0], ser_in};
        default:  shadow_r <= shadow_r;
      endcase
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    state_nx_s    = state_r;
    cmd_ready     = 1'b0;
    clt           = CLT_HOLD;
    d             = {N{1'b0}};
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    done          = 1'b0;
    res_data      = {N{1'b0}};
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        clt = CLT_LOAD;
        d   = data_r;
        if (cnt_zero_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        clt           = shift_clt(dir_r);
        d             = dir_r ? {ser_in, {(N-1){1'b0}}} : {{(N-1){1'b0}}, ser_in};
        ser_out       = dir_r ? shadow_r[0] : shadow_r[N-1];
        ser_out_valid = 1'b1;
        if (last_shift_s || cnt_zero_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        res_data   = shadow_r;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq (N = 8) driving a behavioural uni_shift.
module tb_shift_seq;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic [N-1:0]  cmd_data = '0;
  logic          ser_in = 1'b0;
  logic [1:0]    clt;
  logic [N-1:0]  d;
  logic          ser_out;
  logic          ser_out_valid;
  logic          done;
  logic [N-1:0]  res_data;

  shift_seq #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data), .ser_in(ser_in),
    .clt(clt), .d(d), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .done(done), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural downstream uni_shift
  logic [N-1:0] q_ds;
  always @(posedge clk or negedge rst) begin
    if (!rst) q_ds <= '0;
    else begin
      case (clt)
        2'b01:   q_ds <= {q_ds[N-2:0], d[0]};
        2'b10:   q_ds <= {d[N-1], q_ds[N-1:1]};
        2'b11:   q_ds <= d;
        default: q_ds <= q_ds;
      endcase
    end
  end

  typedef struct {
    logic [N-1:0] data;
    logic         dir;
    logic         sin;
    int           leff;
    logic [N-1:0] res;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int nbits = 0;
  int last_issue = 0;
  int last_leff = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // reference: result of L single-bit shifts with constant serial input
  function automatic logic [N-1:0] model(input logic [N-1:0] dt, input logic dir,
                                        input int l, input logic sin);
    int v, fill;
    v = int'(dt);
    fill = sin ? ((1 << l) - 1) : 0;
    if (!dir) v = (v << l) | fill;
    else      v = (v >> l) | (fill << (N - l));
    return N'(v & ((1 << N) - 1));
  endfunction

  // monitor: pops expectations when the DUT presents serial bits and done
  always @(negedge clk) begin
    if (!rst) begin
      nbits = 0;
    end else begin
      if (ser_out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_ser_out_valid", 1, 0);
        else begin
          exp_t e;
          logic [N-1:0] ed;
          e = exp_q[0];
          ed = e.dir ? {e.sin, 7'b0} : {7'b0, e.sin};
          if (nbits < N) chk("ser_out_bit", int'(ser_out), int'(e.dir ? e.data[nbits] : e.data[N-1-nbits]));
          else chk("too_many_shifts", nbits, e.leff);
          chk("clt_shift", int'(clt), e.dir ? 2 : 1);
          chk("d_shift", int'(d), int'(ed));
          nbits++;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_data", int'(res_data), int'(e.res));
          chk("res_vs_downstream_q", int'(res_data), int'(q_ds));
          chk("shift_count", nbits, e.leff);
          chk("done_cycle", cyc, e.done_cyc);
          chk("clt_done", int'(clt), 0);
          nbits = 0;
        end
      end
    end
  end

  // issue one command at a negedge once cmd_ready is seen; returns one negedge later
  task automatic issue(input logic [N-1:0] dt, input logic dr, input int ln,
                       input logic sn, input logic [N-1:0] res, input bit hold,
                       input bit spacing);
    int w = 0;
    exp_t e;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("ready_timeout", 0, 1);
    if (spacing) chk("b2b_spacing", cyc - last_issue, last_leff + 3);
    cmd_valid = 1'b1;
    cmd_data  = dt;
    cmd_dir   = dr;
    cmd_len   = CW'(ln);
    ser_in    = sn;
    e.data = dt; e.dir = dr; e.sin = sn;
    e.leff = (ln > N) ? N : ln;
    e.res  = res;
    e.done_cyc = cyc + e.leff + 2;
    exp_q.push_back(e);
    last_issue = cyc;
    last_leff  = e.leff;
    @(negedge clk);
    chk("ready_low_after_accept", int'(cmd_ready), 0);
    if (hold) begin
      cmd_data = N'($urandom);
      cmd_dir  = 1'($urandom);
      cmd_len  = CW'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_clt", int'(clt), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res", int'(res_data), 0);
    chk("rst_sov", int'(ser_out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(8'hA5, 1'b0, 3, 1'b1, 8'h2F, 1'b0, 1'b0);
    drain();
    issue(8'hA5, 1'b1, 4, 1'b0, 8'h0A, 1'b0, 1'b0);
    drain();
    issue(8'h3C, 1'b0, 0, 1'b1, 8'h3C, 1'b0, 1'b0);
    drain();
    issue(8'h3C, 1'b0, 12, 1'b1, 8'hFF, 1'b0, 1'b0);
    drain();

    // held cmd_valid, back-to-back commands
    issue(8'h96, 1'b1, 2, 1'b1, 8'hE5, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      logic [N-1:0] dt;
      logic dr, sn;
      int ln;
      dt = N'($urandom); dr = 1'($urandom); sn = 1'($urandom);
      ln = $urandom_range(0, 15);
      issue(dt, dr, ln, sn, model(dt, dr, (ln > N) ? N : ln, sn), 1'b1, 1'b1);
    end
    cmd_valid = 1'b0;
    drain();

    // reset in the 2nd SHIFT cycle aborts the command
    issue(8'h5A, 1'b0, 5, 1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_clt", int'(clt), 0);
    chk("abort_d", int'(d), 0);
    chk("abort_ser_out", int'(ser_out), 0);
    chk("abort_sov", int'(ser_out_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_res", int'(res_data), 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(8'hC3, 1'b1, 3, 1'b1, 8'hF8, 1'b0, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    // random commands with idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] dt;
      logic dr, sn;
      int ln;
      dt = N'($urandom); dr = 1'($urandom); sn = 1'($urandom);
      ln = $urandom_range(0, 15);
      issue(dt, dr, ln, sn, model(dt, dr, (ln > N) ? N : ln, sn), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
